// File: rtl/finv_arbiter.sv
// Round-robin share of one combinational IEEE-754 reciprocal (finv) among NREQ requesters; optional FINV_ARB_SPECIAL_EN.
// Latency: response valid LATENCY+1 cycles after the grant (1 cycle for special operands when FINV_ARB_SPECIAL_EN).
// Backpressure: result held in RESP until rsp_ready; no new grant until the cycle after the response handshake.

module finv (
   input  logic [31:0] x,
   output logic [31:0] y
);
   localparam logic [49:0] NUM = {1'b1, 49'd0};

   logic        s;
   logic [7:0]  e;
   logic [22:0] f;
   logic [49:0] den;
   logic [26:0] q;
   logic        rem_nz;
   logic        up;
   logic [24:0] m;
   logic [9:0]  ex;
   logic [22:0] frac;

   assign s      = x[31];
   assign e      = x[30:23];
   assign f      = x[22:0];
   assign den    = {26'd0, 1'b1, f};
   // 2^49 / 1.f scaled: q[26] set only for an exact power of two, else q[25] leads.
   assign q      = 27'(NUM / den);
   assign rem_nz = (NUM % den) != '0;
   assign up     = q[1] & (q[0] | rem_nz | q[2]);
   assign m      = {1'b0, q[25:2]} + {24'd0, up};

   always_comb begin
      y    = '0;
      ex   = '0;
      frac = '0;
      if (e == 8'h00) begin
         y = {s, 8'hff, 23'h0};
      end else if (e == 8'hff) begin
         y = (f == '0) ? {s, 31'h0} : 32'h7fc0_0000;
      end else begin
         if (q[26]) begin
            ex   = 10'd254 - {2'b00, e};
            frac = '0;
         end else begin
            ex   = 10'd253 - {2'b00, e} + {9'd0, m[24]};
            frac = m[24] ? m[23:1] : m[22:0];
         end
         // Results below the normal range flush to signed zero.
         y = (ex[9] || ex == '0) ? {s, 31'h0} : {s, ex[7:0], frac};
      end
   end
endmodule

module finv_arbiter #(
   parameter int NREQ    = 4,
   parameter int LATENCY = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*32-1:0]        req_x,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [31:0]               rsp_y,
   output logic                      busy
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   if (LATENCY < 1) begin : g_latency_check
      $error("finv_arbiter: LATENCY must be >= 1");
   end
   if (NREQ < 2) begin : g_nreq_check
      $error("finv_arbiter: NREQ must be >= 2");
   end

   logic [1:0]     state;
   logic [IDW-1:0] rr_ptr;
   logic [CW-1:0]  cnt;
   logic [31:0]    x_q;
   logic [31:0]    y_q;
   logic [IDW-1:0] id_q;
   logic [31:0]    finv_y;

   logic           hi_found, lo_found, gnt_vld;
   logic [IDW-1:0] hi_idx, lo_idx, gnt_idx, gnt_nxt;
   logic [31:0]    sel_x;
   logic           take;

   finv u_finv (
      .x (x_q),
      .y (finv_y)
   );

   // Requesters at or above rr_ptr win over the wrapped-around ones below it.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_found = 1'b0;
      lo_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!hi_found && req_valid[i] && IDW'(i) >= rr_ptr) begin
            hi_found = 1'b1;
            hi_idx   = IDW'(i);
         end
         if (!lo_found && req_valid[i]) begin
            lo_found = 1'b1;
            lo_idx   = IDW'(i);
         end
      end
      gnt_vld = hi_found | lo_found;
      gnt_idx = hi_found ? hi_idx : lo_idx;
      gnt_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
   end

   always_comb begin
      sel_x = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == gnt_idx) sel_x = req_x[32*i +: 32];
      end
   end

   assign take = (state == IDLE) && !rst && gnt_vld;

   always_comb begin
      req_ready = '0;
      if (take) req_ready[gnt_idx] = 1'b1;
   end

`ifdef FINV_ARB_SPECIAL_EN
   logic        sp_hit;
   logic [31:0] sp_y;

   always_comb begin
      sp_hit = 1'b1;
      sp_y   = '0;
      if (sel_x[30:23] == 8'h00)
         sp_y = {sel_x[31], 8'hff, 23'h0};
      else if (sel_x[30:23] == 8'hff)
         sp_y = (sel_x[22:0] == '0) ? {sel_x[31], 31'h0} : 32'h7fc0_0000;
      else
         sp_hit = 1'b0;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rr_ptr <= '0;
         cnt    <= '0;
         x_q    <= '0;
         y_q    <= '0;
         id_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  x_q    <= sel_x;
                  id_q   <= gnt_idx;
                  rr_ptr <= gnt_nxt;
                  cnt    <= CW'(LATENCY - 1);
`ifdef FINV_ARB_SPECIAL_EN
                  if (sp_hit) begin
                     y_q   <= sp_y;
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                  end
`else
                  state  <= WAIT;
`endif
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  y_q   <= finv_y;
                  state <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rsp_valid = (state == RESP);
   assign rsp_y     = y_q;
   assign rsp_id    = id_q;
   assign busy      = (state != IDLE);
endmodule

// File: tb/tb_finv_arbiter.sv
// Randomized + directed bench for finv_arbiter; reciprocal reference uses real arithmetic, grants follow round-robin rules.
// Honors FINV_ARB_SPECIAL_EN for the special-operand response timing.
module tb_finv_arbiter;
   localparam int N   = 4;
   localparam int LAT = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*32-1:0] req_x;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [31:0]     rsp_y;
   logic            busy;

   typedef struct {
      int          id;
      logic [31:0] y;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_grant = 0;
   int   n_rsp   = 0;
   int   ptr     = 0;
   bit   seen    = 0;

   finv_arbiter #(.NREQ(N), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit is_special(input logic [31:0] x);
      return (x[30:23] == 8'h00) || (x[30:23] == 8'hff);
   endfunction

   // Reciprocal via double precision, then round-to-nearest-even to single.
   function automatic logic [31:0] ref_finv(input logic [31:0] x);
      logic        s;
      logic [7:0]  e;
      logic [22:0] f;
      real         xr, yr;
      logic [63:0] d;
      int          ed;
      logic [23:0] m;
      logic        g, st;
      logic [24:0] mr;
      s = x[31];
      e = x[30:23];
      f = x[22:0];
      if (e == 8'h00) return {s, 8'hff, 23'h0};
      if (e == 8'hff) return (f == '0) ? {s, 31'h0} : 32'h7fc0_0000;
      xr = $bitstoreal({s, 11'(int'(e) - 127 + 1023), f, 29'h0});
      yr = 1.0 / xr;
      d  = $realtobits(yr);
      ed = int'(d[62:52]) - 1023 + 127;
      m  = {1'b1, d[51:29]};
      g  = d[28];
      st = |d[27:0];
      mr = {1'b0, m} + 25'(g & (st | m[0]));
      if (mr[24]) begin
         ed++;
         mr = mr >> 1;
      end
      if (ed <= 0) return {s, 31'h0};
      return {s, 8'(ed), mr[22:0]};
   endfunction

   function automatic int due_of(input int t, input logic [31:0] x);
`ifdef FINV_ARB_SPECIAL_EN
      if (is_special(x)) return t + 1;
`endif
      return t + LAT + 1;
   endfunction

   // Arbitration model: at most one op outstanding, grant the first valid requester from ptr.
   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      int           g;
      exp_t         e;
      exp_rdy = '0;
      g       = -1;
      if (!rst && n_grant == n_rsp) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("busy", 32'(busy), 32'(n_grant != n_rsp));
      if (rst) begin
         sb.delete();
         n_grant = 0;
         n_rsp   = 0;
         ptr     = 0;
      end else if (g >= 0) begin
         e.id  = g;
         e.y   = ref_finv(req_x[32*g +: 32]);
         e.due = due_of(cyc, req_x[32*g +: 32]);
         sb.push_back(e);
         n_grant++;
         ptr = (g + 1) % N;
      end
   end

   // Response monitor: latency of first valid, payload every valid cycle, pop on handshake.
   always begin
      @(negedge clk);
      #1;
      if (rst) begin
         seen = 0;
      end else if (sb.size() == 0) begin
         check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      end else if (rsp_valid) begin
         if (!seen) begin
            check("rsp_latency", 32'(cyc), 32'(sb[0].due));
            seen = 1;
         end
         check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
         check("rsp_y", rsp_y, sb[0].y);
         if (rsp_ready) begin
            void'(sb.pop_front());
            n_rsp++;
            seen = 0;
         end
      end else if (!seen && cyc > sb[0].due) begin
         check("rsp_late", 32'(rsp_valid), 32'd1);
         seen = 1;
      end
   end

   task automatic drive(input logic [N-1:0] v, input logic rr, input logic r);
      req_valid = v;
      rsp_ready = rr;
      rst       = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive('0, 1'b1, 1'b0);
   endtask

   function automatic logic [31:0] rand_op();
      logic s;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 19))
         0:       return {s, 8'h00, 23'h0};
         1:       return {s, 8'h00, 23'($urandom)};
         2:       return {s, 8'hff, 23'h0};
         3:       return {s, 8'hff, 23'($urandom) | 23'h1};
         default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
      endcase
   endfunction

   task automatic rand_ops();
      for (int i = 0; i < N; i++) req_x[32*i +: 32] = rand_op();
   endtask

   logic [31:0] specials [6];

   initial begin
      specials[0] = 32'h8000_0000;
      specials[1] = 32'h7f80_0001;
      specials[2] = 32'h0000_0000;
      specials[3] = 32'h7f80_0000;
      specials[4] = 32'hff80_0000;
      specials[5] = 32'h0000_0123;
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_x = '0;
      drive('0, 1'b0, 1'b1);
      drive('0, 1'b0, 1'b1);

      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_y", rsp_y, 32'd0);
      check("reset_rsp_id", 32'(rsp_id), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);

      // Single request from requester 0 with x = 2.0
      req_x[31:0] = 32'h4000_0000;
      drive(4'b0001, 1'b1, 1'b0);
      idle(6);

      // All requesters continuously valid after reset
      drive('0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         rand_ops();
         drive(4'b1111, 1'b1, 1'b0);
      end
      idle(5);

      // Grant 2, then 3 must beat 1
      rand_ops();
      drive(4'b0100, 1'b1, 1'b0);
      idle(5);
      rand_ops();
      drive(4'b1010, 1'b1, 1'b0);
      idle(5);

      // Consumer stalls in RESP
      rand_ops();
      req_x[31:0] = 32'h3fc0_0000;
      drive(4'b0001, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive(4'b1111, 1'b0, 1'b0);
      idle(3);

      // Reset during WAIT discards the op and rewinds priority
      rand_ops();
      drive(4'b0010, 1'b1, 1'b0);
      drive(4'b1111, 1'b0, 1'b1);
      drive(4'b1111, 1'b1, 1'b0);
      idle(6);

      // Special operands
      foreach (specials[k]) begin
         req_x[95:64] = specials[k];
         drive(4'b0100, 1'b1, 1'b0);
         idle(5);
      end

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         rand_ops();
         drive(N'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
      end

      for (int i = 0; i < 100 && sb.size() != 0; i++) drive('0, 1'b1, 1'b0);
      check("drain_empty", 32'(sb.size()), 32'd0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
